pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds one instruction for decode, fetches the next on consume.
// Three-state FSM (FETCH/ISSUE/FAULT) with sticky fault on misaligned redirect targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misaligned_fault,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] instret_q, instret_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            fault_q   <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    // NOTE: every next-state signal is defaulted to its current value first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    instret_d = instret_q + 32'd1;
                    instr_d   = NOP_INSTR;
                    if (!PCSrc) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end else if (PCTarget[1:0] == 2'b00) begin
                        pc_d    = PCTarget;
                        state_d = FETCH;
                    end else begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Request is gated by rst_n so nothing is issued while reset is held.
    assign imem_req         = rst_n && (state_q == FETCH);
    assign imem_addr        = {pc_q[31:2], 2'b00};
    assign Instr            = instr_q;
    assign PC               = pc_q;
    assign PCPlus4          = pc_q + 32'd4;
    assign instr_valid      = (state_q == ISSUE);
    assign misaligned_fault = fault_q;
    assign instret          = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: scoreboard of fetched words, per-scenario tasks.
// A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid, misaligned_fault;
    logic [31:0] imem_addr, Instr, PC, PCPlus4, instret;

    logic        w_imem_req, w_instr_valid, w_misaligned_fault;
    logic [31:0] w_imem_addr, w_Instr, w_PC, w_PCPlus4, w_instret;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .instr_valid(instr_valid), .misaligned_fault(misaligned_fault), .instret(instret)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .Instr(w_Instr), .PC(w_PC), .PCPlus4(w_PCPlus4),
        .instr_valid(w_instr_valid), .misaligned_fault(w_misaligned_fault), .instret(w_instret)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'd0) return 32'h0050_0093;
        return {addr[15:0], 16'h0213} ^ 32'h5A5A_0000;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = 32'd0;
        stall      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        m_pc      = 32'd0;
        m_instret = 32'd0;
        sb_q.delete();
        #1;
    endtask

    // Starts at a negedge in FETCH; ends at a negedge after the consume edge.
    task automatic fetch_issue(input int wait_cycles, input int stall_cycles,
                               input logic pcsrc, input logic [31:0] target);
        sb_entry_t e;
        for (int i = 0; i < wait_cycles; i++) begin
            imem_ready = 1'b0;
            imem_rdata = 32'hBAD0_0000 | i;
            cmp("wait_req", {31'd0, imem_req}, 32'd1);
            cmp("wait_addr", imem_addr, m_pc);
            cmp("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        cmp("fetch_req", {31'd0, imem_req}, 32'd1);
        cmp("fetch_addr", imem_addr, m_pc);
        imem_ready = 1'b1;
        imem_rdata = mem_word(m_pc);
        sb_q.push_back('{pc: m_pc, instr: imem_rdata});
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD1_1111;
        cmp("issue_valid", {31'd0, instr_valid}, 32'd1);
        cmp("issue_req", {31'd0, imem_req}, 32'd0);
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            cmp("issue_instr", Instr, e.instr);
            cmp("issue_pc", PC, e.pc);
        end
        cmp("issue_pcplus4", PCPlus4, m_pc + 32'd4);
        PCSrc    = pcsrc;
        PCTarget = target;
        for (int i = 0; i < stall_cycles; i++) begin
            stall = 1'b1;
            @(negedge clk);
            cmp("stall_pc", PC, m_pc);
            cmp("stall_instret", instret, m_instret);
            cmp("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        m_instret = m_instret + 32'd1;
        cmp("consume_instret", instret, m_instret);
        if (pcsrc && target[1:0] != 2'b00) begin
            cmp("fault_flag", {31'd0, misaligned_fault}, 32'd1);
            cmp("fault_pc", PC, m_pc);
            cmp("fault_req", {31'd0, imem_req}, 32'd0);
            cmp("fault_valid", {31'd0, instr_valid}, 32'd0);
        end else begin
            m_pc = pcsrc ? target : m_pc + 32'd4;
            cmp("next_addr", imem_addr, m_pc);
            cmp("next_req", {31'd0, imem_req}, 32'd1);
            cmp("next_instr_nop", Instr, NOP);
        end
        PCSrc    = 1'b0;
        PCTarget = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        PCSrc = 1'b0; PCTarget = 32'd0; stall = 1'b0;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        cmp("rst_req", {31'd0, imem_req}, 32'd0);
        cmp("rst_valid", {31'd0, instr_valid}, 32'd0);
        cmp("rst_pc", PC, 32'd0);
        cmp("rst_instr", Instr, NOP);
        cmp("rst_fault", {31'd0, misaligned_fault}, 32'd0);
        cmp("rst_instret", instret, 32'd0);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        m_pc = 32'd0; m_instret = 32'd0;
        #1;
        cmp("post_rst_req", {31'd0, imem_req}, 32'd1);
        cmp("post_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_basic();
        fetch_issue(0, 0, 1'b0, 32'd0);
    endtask

    task automatic test_wait_states();
        fetch_issue(0, 0, 1'b0, 32'd0);
        fetch_issue(3, 0, 1'b0, 32'd0);
    endtask

    task automatic test_stall_redirect();
        cmp("stall_setup_pc", PC, 32'd12);
        fetch_issue(0, 2, 1'b1, 32'h40);
    endtask

    task automatic test_back_to_back();
        logic      fetching = 1'b1;
        sb_entry_t e;
        for (int c = 0; c < 8; c++) begin
            imem_ready = 1'b1;
            stall      = 1'b0;
            imem_rdata = mem_word(imem_addr);
            if (fetching) begin
                cmp("b2b_req", {31'd0, imem_req}, 32'd1);
                cmp("b2b_addr", imem_addr, m_pc);
                sb_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
            end else begin
                cmp("b2b_valid", {31'd0, instr_valid}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    cmp("b2b_instr", Instr, e.instr);
                    cmp("b2b_pc", PC, e.pc);
                end
                m_pc      = m_pc + 32'd4;
                m_instret = m_instret + 32'd1;
            end
            fetching = !fetching;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        cmp("b2b_instret", instret, m_instret);
        cmp("b2b_final_addr", imem_addr, m_pc);
    endtask

    task automatic test_async_reset();
        imem_ready = 1'b1;
        imem_rdata = mem_word(m_pc);
        @(negedge clk);
        imem_ready = 1'b0;
        stall      = 1'b1;
        @(negedge clk);
        cmp("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp("ar_valid", {31'd0, instr_valid}, 32'd0);
        cmp("ar_pc", PC, 32'd0);
        cmp("ar_instr", Instr, NOP);
        cmp("ar_instret", instret, 32'd0);
        cmp("ar_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        apply_reset();
        cmp("ar_release_addr", imem_addr, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        fetch_issue(0, 0, 1'b0, 32'd0);
        fetch_issue(0, 0, 1'b1, 32'h42);
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0093;
        repeat (4) @(negedge clk);
        cmp("fault_hold_req", {31'd0, imem_req}, 32'd0);
        cmp("fault_hold_flag", {31'd0, misaligned_fault}, 32'd1);
        cmp("fault_hold_instr", Instr, NOP);
        cmp("fault_hold_valid", {31'd0, instr_valid}, 32'd0);
        cmp("fault_hold_pc", PC, 32'd4);
        apply_reset();
        cmp("fault_clr_flag", {31'd0, misaligned_fault}, 32'd0);
        cmp("fault_clr_addr", imem_addr, 32'd0);
        cmp("fault_clr_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic test_wrap();
        cmp("wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
        cmp("wrap_pcplus4", w_PCPlus4, 32'd0);
        imem_ready = 1'b1;
        imem_rdata = 32'h0010_0113;
        stall      = 1'b0;
        PCSrc      = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        cmp("wrap_valid", {31'd0, w_instr_valid}, 32'd1);
        cmp("wrap_instr", w_Instr, 32'h0010_0113);
        cmp("wrap_pcplus4_issue", w_PCPlus4, 32'd0);
        @(negedge clk);
        cmp("wrap_next_addr", w_imem_addr, 32'd0);
        cmp("wrap_next_req", {31'd0, w_imem_req}, 32'd1);
        cmp("wrap_instret", w_instret, 32'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_stall_redirect();
        test_back_to_back();
        test_async_reset();
        test_misaligned();
        test_wrap();
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_leftover got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
